// File: rtl/mod_uart_tx_if.sv
// Handshake/data bundle between a byte producer and the UART transmitter.
//   tx_start  : one-cycle request to send tx_data (producer -> transmitter)
//   tx_data   : byte to send, captured when the request is accepted
//   tx        : serial line, idle high (transmitter -> line)
//   busy      : frame in progress
//   flag_done : one-cycle pulse once the last stop bit has been sent
// master = producer side, slave = transmitter side.
interface mod_uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       busy;
  logic       flag_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  busy,
    input  flag_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output busy,
    output flag_done
  );
endinterface

// File: rtl/mod_uart_tx.sv
// UART transmitter, 8 data bits LSB first, no parity, STOP_BITS stop bits.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mod_uart_tx_if.slave (tx_start, tx_data in; tx, busy, flag_done out)
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   STOP_BITS    : 1 or 2
// A request is accepted only in IDLE; the start bit appears on the edge after
// the request cycle. flag_done pulses in the first IDLE cycle after the last
// stop bit, so a request in that cycle starts the next frame immediately.
module mod_uart_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  mod_uart_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic             stop_cnt;
  logic [7:0]       shreg;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic bit_end;
  logic stop_last;

  assign bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.tx_start) begin
            shreg   <= bus.tx_data;
            clk_cnt <= '0;
            state   <= ST_START;
            // line is registered, so the start bit is driven from this edge
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            tx_q    <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              stop_cnt <= 1'b0;
              state    <= ST_STOP;
              tx_q     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // next bit is presented on the same edge the index advances
              tx_q    <= shreg[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (stop_last) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.flag_done = done_q;

endmodule
